// File: rtl/usb_gpx_event_ctl_if.sv
// Avalon-MM slave bus plus interrupt line for the GPX event controller.
interface usb_gpx_event_ctl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/usb_gpx_event_ctl.sv
// GPX pin event controller: synchronizer, glitch filter, edge capture,
// saturating event counter and maskable level interrupt.
module usb_gpx_event_ctl #(
  parameter int FILTER_CYCLES = 8,
  parameter int CNT_W         = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           in_port,
  usb_gpx_event_ctl_if.slave bus
);

  localparam int FC_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  // Filter timer counts down from FILTER_CYCLES-1; firing at zero means
  // FILTER_CYCLES consecutive edges saw sync differ from filtered.
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sync_1, sync_2;
  logic             filtered, filt_next;
  logic [FC_W-1:0]  filt_cnt, filt_cnt_next;
  logic [3:0]       ctrl;
  logic             capture;
  logic [CNT_W-1:0] count;
  logic             wr_en, ctrl_wr, edge_wr, count_wr;
  logic             evt;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign ctrl_wr  = wr_en & (bus.address == 2'd1);
  assign edge_wr  = wr_en & (bus.address == 2'd2);
  assign count_wr = wr_en & (bus.address == 2'd3);

  assign unused_wdata = ^bus.writedata[31:4];

  // Next filtered level and filter timer; a filt_en toggle restarts the timer.
  always_comb begin
    filt_next     = filtered;
    filt_cnt_next = FC_LOAD;
    if (!ctrl[3]) begin
      filt_next = sync_2;
    end else if (sync_2 != filtered) begin
      if (filt_cnt == '0) begin
        filt_next = sync_2;
      end else begin
        filt_cnt_next = filt_cnt - 1'b1;
      end
    end
    if (ctrl_wr && (bus.writedata[3] != ctrl[3])) begin
      filt_cnt_next = FC_LOAD;
    end
  end

  // Qualified edge on the filtered level: ctrl[1] selects rise, ctrl[2] fall.
  assign evt = (filt_next & ~filtered & ctrl[1]) | (~filt_next & filtered & ctrl[2]);

  // Read mux reflects register values ahead of this edge's updates.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      2'd0: rd_mux = {30'd0, sync_2, filtered};
      2'd1: rd_mux = {28'd0, ctrl};
      2'd2: rd_mux = {31'd0, capture};
      2'd3: rd_mux = 32'(count);
      default: rd_mux = '0;
    endcase
  end

  // Synchronizer, filter state and registered read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1       <= 1'b0;
      sync_2       <= 1'b0;
      filtered     <= 1'b0;
      filt_cnt     <= FC_LOAD;
      bus.readdata <= '0;
    end else begin
      sync_1       <= in_port;
      sync_2       <= sync_1;
      filtered     <= filt_next;
      filt_cnt     <= filt_cnt_next;
      bus.readdata <= rd_mux;
    end
  end

  // Control register, sticky capture (set beats clear) and saturating counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl    <= '0;
      capture <= 1'b0;
      count   <= '0;
    end else begin
      if (ctrl_wr) begin
        ctrl <= bus.writedata[3:0];
      end
      if (evt) begin
        capture <= 1'b1;
      end else if (edge_wr && bus.writedata[0]) begin
        capture <= 1'b0;
      end
      if (count_wr) begin
        count <= evt ? CNT_W'(1) : '0;
      end else if (evt && (count != CNT_MAX)) begin
        count <= count + 1'b1;
      end
    end
  end

  assign bus.irq = ctrl[0] & capture;

endmodule

// File: tb/tb_usb_gpx_event_ctl.sv
// Bench for usb_gpx_event_ctl: two instances (16-bit and 4-bit counters)
// driven in lockstep, a cycle-level reference model, register vector table,
// directed corner sequences and a randomized phase.
module tb_usb_gpx_event_ctl;

  localparam int FILT = 8;

  logic        clk = 1'b0;
  logic        t_rst = 1'b0;
  logic        t_in = 1'b0;
  logic [1:0]  t_addr = '0;
  logic        t_cs = 1'b0;
  logic        t_wn = 1'b1;
  logic [31:0] t_wd = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  usb_gpx_event_ctl_if bus0 ();
  usb_gpx_event_ctl_if bus1 ();

  assign bus0.address = t_addr;  assign bus1.address = t_addr;
  assign bus0.chipselect = t_cs; assign bus1.chipselect = t_cs;
  assign bus0.write_n = t_wn;    assign bus1.write_n = t_wn;
  assign bus0.writedata = t_wd;  assign bus1.writedata = t_wd;

  usb_gpx_event_ctl #(.FILTER_CYCLES(FILT), .CNT_W(16)) dut (
    .clk(clk), .reset_n(t_rst), .in_port(t_in), .bus(bus0)
  );

  usb_gpx_event_ctl #(.FILTER_CYCLES(FILT), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(t_rst), .in_port(t_in), .bus(bus1)
  );

  always #5 clk = ~clk;

  // Reference model: behaviour stated as rules, stepped once per rising edge.
  logic        m_s1, m_sync, m_filt, m_cap, nf, ev, wr;
  logic [3:0]  m_ctrl;
  int          m_run;
  int          m_cnt [2];
  int          m_max [2] = '{65535, 15};
  logic [31:0] m_rd [2];

  function automatic logic [31:0] model_read(input logic [1:0] a, input int idx);
    case (a)
      2'd0: return {30'd0, m_sync, m_filt};
      2'd1: return {28'd0, m_ctrl};
      2'd2: return {31'd0, m_cap};
      default: return 32'(m_cnt[idx]);
    endcase
  endfunction

  always @(posedge clk) begin
    if (!t_rst) begin
      m_s1 = 0; m_sync = 0; m_filt = 0; m_run = 0; m_ctrl = 0; m_cap = 0;
      m_cnt[0] = 0; m_cnt[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
    end else begin
      wr = t_cs && !t_wn;
      m_rd[0] = model_read(t_addr, 0);
      m_rd[1] = model_read(t_addr, 1);
      nf = m_filt;
      if (!m_ctrl[3]) begin
        nf = m_sync; m_run = 0;
      end else if (m_sync != m_filt) begin
        m_run = m_run + 1;
        if (m_run >= FILT) begin nf = m_sync; m_run = 0; end
      end else begin
        m_run = 0;
      end
      if (wr && t_addr == 2'd1 && t_wd[3] != m_ctrl[3]) m_run = 0;
      ev = (nf != m_filt) && (nf ? m_ctrl[1] : m_ctrl[2]);
      m_sync = m_s1;
      m_s1 = t_in;
      if (ev) m_cap = 1;
      else if (wr && t_addr == 2'd2 && t_wd[0]) m_cap = 0;
      for (int i = 0; i < 2; i++) begin
        if (wr && t_addr == 2'd3) m_cnt[i] = 0;
        if (ev && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
      end
      if (wr && t_addr == 2'd1) m_ctrl = t_wd[3:0];
      m_filt = nf;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_rd16", bus0.readdata, m_rd[0]);
      check("model_rd4", bus1.readdata, m_rd[1]);
      check("model_irq16", {31'd0, bus0.irq}, {31'd0, m_ctrl[0] & m_cap});
      check("model_irq4", {31'd0, bus1.irq}, {31'd0, m_ctrl[0] & m_cap});
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    t_addr = a; t_wd = d; t_cs = 1'b1; t_wn = 1'b0;
    @(posedge clk); #1;
    t_cs = 1'b0; t_wn = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    t_addr = a; t_cs = 1'b0; t_wn = 1'b1;
    @(posedge clk); #1;
    d = bus0.readdata;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  addr;
    bit          wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int hold;

    vecs[0]  = '{2'd1, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{2'd1, 1'b1, 32'hFFFF_FFF0, 32'h0};
    vecs[2]  = '{2'd1, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{2'd1, 1'b1, 32'h0000_0005, 32'h0};
    vecs[4]  = '{2'd1, 1'b0, 32'h0,         32'h5};
    vecs[5]  = '{2'd1, 1'b1, 32'h0000_00FA, 32'h0};
    vecs[6]  = '{2'd1, 1'b0, 32'h0,         32'hA};
    vecs[7]  = '{2'd0, 1'b1, 32'hFFFF_FFFF, 32'h0};
    vecs[8]  = '{2'd1, 1'b0, 32'h0,         32'hA};
    vecs[9]  = '{2'd2, 1'b0, 32'h0,         32'h0};
    vecs[10] = '{2'd3, 1'b0, 32'h0,         32'h0};
    vecs[11] = '{2'd1, 1'b1, 32'h0,         32'h0};
    vecs[12] = '{2'd0, 1'b0, 32'h0,         32'h0};

    // Reset held with the pin high.
    t_rst = 1'b0; t_in = 1'b1;
    wait_cycles(1);
    chk_on = 1'b1;
    wait_cycles(2);
    check("reset_rd16", bus0.readdata, 32'h0);
    check("reset_rd4", bus1.readdata, 32'h0);
    check("reset_irq", {31'd0, bus0.irq}, 32'h0);
    t_rst = 1'b1; t_in = 1'b0;
    wait_cycles(4);
    bus_read(2'd3, rd);
    check("reset_count", rd, 32'h0);

    // Register access table.
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) begin
        bus_write(vecs[i].addr, vecs[i].wdata);
      end else begin
        bus_read(vecs[i].addr, rd);
        check($sformatf("vec%0d", i), rd, vecs[i].exp);
      end
    end

    // Unfiltered rising edge: DATA, capture, irq, count, W1C.
    bus_write(2'd1, 32'h3);
    t_addr = 2'd0;
    t_in = 1'b1;
    wait_cycles(1);
    check("rise_irq_e1", {31'd0, bus0.irq}, 32'h0);
    wait_cycles(1);
    check("rise_irq_e2", {31'd0, bus0.irq}, 32'h0);
    check("rise_data_e2", bus0.readdata, 32'h0);
    wait_cycles(1);
    check("rise_irq_e3", {31'd0, bus0.irq}, 32'h1);
    check("rise_data_e3", bus0.readdata, 32'h2);
    wait_cycles(1);
    check("rise_data_e4", bus0.readdata, 32'h3);
    bus_read(2'd3, rd);
    check("rise_count", rd, 32'h1);
    bus_write(2'd2, 32'h1);
    check("w1c_irq", {31'd0, bus0.irq}, 32'h0);

    // Glitch filter: 7-cycle pulse rejected, 8-cycle level accepted.
    t_in = 1'b0;
    wait_cycles(4);
    bus_write(2'd1, 32'hB);
    bus_write(2'd3, 32'h0);
    bus_write(2'd2, 32'h1);
    t_in = 1'b1;
    wait_cycles(7);
    t_in = 1'b0;
    wait_cycles(12);
    bus_read(2'd0, rd);
    check("filt7_data", rd, 32'h0);
    bus_read(2'd3, rd);
    check("filt7_count", rd, 32'h0);
    t_in = 1'b1;
    wait_cycles(12);
    bus_read(2'd0, rd);
    check("filt8_data", rd, 32'h3);
    bus_read(2'd3, rd);
    check("filt8_count", rd, 32'h1);
    check("filt8_irq", {31'd0, bus0.irq}, 32'h1);
    t_in = 1'b0;
    wait_cycles(14);
    bus_read(2'd0, rd);
    check("filt_fall_data", rd, 32'h0);

    // Falling-edge only selection.
    bus_write(2'd1, 32'h5);
    bus_write(2'd3, 32'h0);
    bus_write(2'd2, 32'h1);
    t_in = 1'b1;
    wait_cycles(5);
    bus_read(2'd3, rd);
    check("fall_after_rise_count", rd, 32'h0);
    check("fall_after_rise_irq", {31'd0, bus0.irq}, 32'h0);
    t_in = 1'b0;
    wait_cycles(5);
    bus_read(2'd3, rd);
    check("fall_count", rd, 32'h1);
    check("fall_irq", {31'd0, bus0.irq}, 32'h1);

    // Event coinciding with EDGE clear: set wins.
    bus_write(2'd1, 32'h3);
    bus_write(2'd2, 32'h1);
    check("pre_coll_irq", {31'd0, bus0.irq}, 32'h0);
    t_in = 1'b1;
    wait_cycles(2);
    bus_write(2'd2, 32'h1);
    check("coll_w1c_irq", {31'd0, bus0.irq}, 32'h1);
    bus_read(2'd2, rd);
    check("coll_w1c_edge", rd, 32'h1);
    bus_read(2'd3, rd);
    check("coll_w1c_count", rd, 32'h2);

    // Event coinciding with COUNT clear: result is one.
    t_in = 1'b0;
    wait_cycles(4);
    bus_write(2'd2, 32'h1);
    t_in = 1'b1;
    wait_cycles(2);
    bus_write(2'd3, 32'h0);
    bus_read(2'd3, rd);
    check("coll_cnt_count", rd, 32'h1);

    // Saturation of the 4-bit counter after 17 rising edges.
    t_in = 1'b0;
    wait_cycles(4);
    bus_write(2'd3, 32'h0);
    for (int i = 0; i < 17; i++) begin
      t_in = 1'b1;
      wait_cycles(3);
      t_in = 1'b0;
      wait_cycles(3);
    end
    bus_read(2'd3, rd);
    check("sat_count16", rd, 32'd17);
    check("sat_count4", bus1.readdata, 32'd15);

    // Reset in the middle of filtering.
    bus_write(2'd1, 32'h9);
    t_in = 1'b1;
    wait_cycles(4);
    t_rst = 1'b0;
    wait_cycles(1);
    check("midrst_rd16", bus0.readdata, 32'h0);
    check("midrst_rd4", bus1.readdata, 32'h0);
    check("midrst_irq", {31'd0, bus0.irq | bus1.irq}, 32'h0);
    wait_cycles(1);
    t_rst = 1'b1;
    bus_read(2'd1, rd);
    check("midrst_ctrl", rd, 32'h0);
    bus_read(2'd2, rd);
    check("midrst_edge", rd, 32'h0);
    bus_read(2'd3, rd);
    check("midrst_count16", rd, 32'h0);
    check("midrst_count4", bus1.readdata, 32'h0);

    // Randomized traffic against the model.
    hold = 1;
    for (int i = 0; i < 800; i++) begin
      hold--;
      if (hold <= 0) begin
        t_in = ~t_in;
        hold = $urandom_range(1, 12);
      end
      t_cs   = ($urandom_range(0, 3) == 0);
      t_wn   = $urandom_range(0, 1);
      t_addr = 2'($urandom_range(0, 3));
      t_wd   = $urandom;
      t_rst  = ($urandom_range(0, 249) != 0);
      wait_cycles(1);
    end
    t_cs = 1'b0; t_wn = 1'b1; t_rst = 1'b1;
    wait_cycles(2);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
